// File: rtl/safe_display_if.sv
// Signal bundle between the safe keypad/comparator side and the display sequencer.
// The master drives the keypad and comparator strobes. The slave drives the decoder codes and the entry buffer.
interface safe_display_if;
   logic [3:0]  digit_in;
   logic        digit_valid;
   logic        clear;
   logic        unlock_ok;
   logic        unlock_fail;
   logic [19:0] code_out;
   logic [3:0]  blink_out;
   logic [15:0] entry_bcd;
   logic [2:0]  entry_count;
   logic        entry_full;
   logic        busy;

   modport master (
      output digit_in, digit_valid, clear, unlock_ok, unlock_fail,
      input  code_out, blink_out, entry_bcd, entry_count, entry_full, busy
   );

   modport slave (
      input  digit_in, digit_valid, clear, unlock_ok, unlock_fail,
      output code_out, blink_out, entry_bcd, entry_count, entry_full, busy
   );
endinterface

// File: rtl/safe_display_ctrl.sv
// Four-digit readout sequencer for the safe: code-entry buffer, cursor blink and timed pass/fail banners.
// The per-digit slices decode the next-state view, and the top registers every output.

module safe_display_digit #(
   parameter int POS = 0
) (
   input  logic       show_pass,
   input  logic       show_fail,
   input  logic [2:0] count,
   input  logic [3:0] nib,
   input  logic       phase,
   output logic [4:0] code,
   output logic       blank
);
   // Position POS holds the (3-POS)-th entered digit, so it is filled once count exceeds that index.
   localparam logic [2:0] SLOT = 3'(3 - POS);

   always_comb begin
      code  = 5'd15;
      blank = 1'b0;
      if (show_pass) begin
         code = 5'd16;
      end else if (show_fail) begin
         blank = phase;
      end else begin
         if (count > SLOT)  code  = {1'b0, nib};
         if (count == SLOT) blank = phase;
      end
   end
endmodule

module safe_display_ctrl #(
   parameter int BLINK_DIV   = 25_000_000,
   parameter int HOLD_CYCLES = 100_000_000
) (
   input  logic          clk,
   input  logic          rst,
   safe_display_if.slave bus
);
   localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
   localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {ENTRY, SHOW_PASS, SHOW_FAIL} state_e;

   state_e          state, state_nxt;
   logic [15:0]     bcd, bcd_nxt;
   logic [2:0]      count, cnt_nxt;
   logic [HW-1:0]   hold_cnt, hold_nxt;
   logic [BW-1:0]   blink_cnt, blink_cnt_nxt;
   logic            phase, phase_nxt;
   logic            restart;
   logic [1:0]      cursor;
   logic [3:0][4:0] code_nxt;
   logic [3:0]      blink_nxt;
   logic [19:0]     code_q;
   logic [3:0]      blink_q;
   logic            busy_q;
   logic            full_q;

   // Next free slot is position 3-count.
   assign cursor = ~count[1:0];

   always_comb begin
      state_nxt = state;
      bcd_nxt   = bcd;
      cnt_nxt   = count;
      hold_nxt  = hold_cnt;
      restart   = 1'b0;
      case (state)
         ENTRY: begin
            if (bus.unlock_ok) begin
               state_nxt = SHOW_PASS;
               hold_nxt  = '0;
               restart   = 1'b1;
            end else if (bus.unlock_fail) begin
               state_nxt = SHOW_FAIL;
               hold_nxt  = '0;
               restart   = 1'b1;
            end else if (bus.clear) begin
               bcd_nxt = '0;
               cnt_nxt = '0;
               restart = 1'b1;
            end else if (bus.digit_valid && count < 3'd4 && bus.digit_in <= 4'd9) begin
               bcd_nxt[4*cursor +: 4] = bus.digit_in;
               cnt_nxt = count + 3'd1;
               restart = 1'b1;
            end
         end
         default: begin
            // The buffer stays readable by the comparator until the banner times out.
            if (hold_cnt == HOLD_LAST) begin
               state_nxt = ENTRY;
               bcd_nxt   = '0;
               cnt_nxt   = '0;
               restart   = 1'b1;
            end else begin
               hold_nxt = hold_cnt + 1'b1;
            end
         end
      endcase

      blink_cnt_nxt = blink_cnt + 1'b1;
      phase_nxt     = phase;
      if (restart) begin
         blink_cnt_nxt = '0;
         phase_nxt     = 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
         blink_cnt_nxt = '0;
         phase_nxt     = ~phase;
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_dig
      safe_display_digit #(.POS(g)) u_dig (
         .show_pass (state_nxt == SHOW_PASS),
         .show_fail (state_nxt == SHOW_FAIL),
         .count     (cnt_nxt),
         .nib       (bcd_nxt[4*g +: 4]),
         .phase     (phase_nxt),
         .code      (code_nxt[g]),
         .blank     (blink_nxt[g])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ENTRY;
         bcd       <= '0;
         count     <= '0;
         hold_cnt  <= '0;
         blink_cnt <= '0;
         phase     <= 1'b0;
         code_q    <= {4{5'd15}};
         blink_q   <= '0;
         busy_q    <= 1'b0;
         full_q    <= 1'b0;
      end else begin
         state     <= state_nxt;
         bcd       <= bcd_nxt;
         count     <= cnt_nxt;
         hold_cnt  <= hold_nxt;
         blink_cnt <= blink_cnt_nxt;
         phase     <= phase_nxt;
         code_q    <= code_nxt;
         blink_q   <= blink_nxt;
         busy_q    <= (state_nxt != ENTRY);
         full_q    <= (cnt_nxt == 3'd4);
      end
   end

   assign bus.code_out    = code_q;
   assign bus.blink_out   = blink_q;
   assign bus.entry_bcd   = bcd;
   assign bus.entry_count = count;
   assign bus.entry_full  = full_q;
   assign bus.busy        = busy_q;
endmodule

// File: tb/tb_safe_display_ctrl.sv
// Directed bench for safe_display_ctrl with BLINK_DIV=4, HOLD_CYCLES=10.
// Expected values are hand-derived; each output is sampled 1 ns after the rising edge.
module tb_safe_display_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk  = 0;
   int   n_pass = 0;

   safe_display_if bus();

   safe_display_ctrl #(.BLINK_DIV(4), .HOLD_CYCLES(10)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, got, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [3:0] d);
      bus.digit_in    = d;
      bus.digit_valid = 1'b1;
      tick();
      bus.digit_valid = 1'b0;
   endtask

   task automatic pulse_clear;
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
   endtask

   function automatic logic [19:0] codes(input int a, input int b, input int c, input int d);
      return {5'(a), 5'(b), 5'(c), 5'(d)};
   endfunction

   function automatic logic ph(input int e);
      return ((e / 4) % 2) != 0;
   endfunction

   localparam logic [19:0] DASHES = {4{5'd15}};

   initial begin
      bus.digit_in    = 4'd0;
      bus.digit_valid = 1'b0;
      bus.clear       = 1'b0;
      bus.unlock_ok   = 1'b0;
      bus.unlock_fail = 1'b0;
      repeat (2) tick();
      chk("rst_code",  32'(bus.code_out), 32'(DASHES));
      chk("rst_blink", 32'(bus.blink_out), 32'h0);
      chk("rst_bcd",   32'(bus.entry_bcd), 32'h0);
      chk("rst_count", 32'(bus.entry_count), 32'h0);
      chk("rst_full",  32'(bus.entry_full), 32'h0);
      chk("rst_busy",  32'(bus.busy), 32'h0);
      rst = 1'b0;

      // Idle: the cursor is on pos 3 and toggles every 4 edges.
      for (int e = 1; e <= 20; e++) begin
         tick();
         chk("idle_blink", 32'(bus.blink_out), ph(e) ? 32'h8 : 32'h0);
      end
      chk("idle_code",  32'(bus.code_out), 32'(DASHES));
      chk("idle_count", 32'(bus.entry_count), 32'h0);

      press(4'd4);
      chk("d1_code",  32'(bus.code_out), 32'(codes(4, 15, 15, 15)));
      chk("d1_blink", 32'(bus.blink_out), 32'h0);
      press(4'd2);
      press(4'd7);
      press(4'd1);
      chk("d4_code",  32'(bus.code_out), 32'(codes(4, 2, 7, 1)));
      chk("d4_bcd",   32'(bus.entry_bcd), 32'h4271);
      chk("d4_full",  32'(bus.entry_full), 32'h1);
      chk("d4_count", 32'(bus.entry_count), 32'h4);
      chk("d4_blink", 32'(bus.blink_out), 32'h0);
      press(4'd9);
      chk("d5_bcd",   32'(bus.entry_bcd), 32'h4271);
      chk("d5_count", 32'(bus.entry_count), 32'h4);
      pulse_clear();
      chk("clr_code",  32'(bus.code_out), 32'(DASHES));
      chk("clr_bcd",   32'(bus.entry_bcd), 32'h0);
      chk("clr_count", 32'(bus.entry_count), 32'h0);
      chk("clr_full",  32'(bus.entry_full), 32'h0);

      // Invalid BCD digit is dropped and does not restart the blink timer.
      press(4'd3);
      press(4'd12);
      press(4'd5);
      chk("inv_bcd",   32'(bus.entry_bcd), 32'h3500);
      chk("inv_code",  32'(bus.code_out), 32'(codes(3, 5, 15, 15)));
      chk("inv_count", 32'(bus.entry_count), 32'h2);
      chk("inv_blink0", 32'(bus.blink_out), 32'h0);
      for (int e = 1; e <= 8; e++) begin
         tick();
         chk("cur1_blink", 32'(bus.blink_out), ph(e) ? 32'h2 : 32'h0);
      end
      press(4'd6);
      press(4'd8);
      chk("full_bcd", 32'(bus.entry_bcd), 32'h3568);
      repeat (5) tick();
      chk("full_blink", 32'(bus.blink_out), 32'h0);

      // fail beats clear in the same cycle
      bus.unlock_fail = 1'b1;
      bus.clear       = 1'b1;
      tick();
      bus.unlock_fail = 1'b0;
      bus.clear       = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (k > 0) tick();
         chk("fail_busy",  32'(bus.busy), 32'h1);
         chk("fail_code",  32'(bus.code_out), 32'(DASHES));
         chk("fail_blink", 32'(bus.blink_out), ph(k) ? 32'hf : 32'h0);
         chk("fail_bcd",   32'(bus.entry_bcd), 32'h3568);
      end
      tick();
      chk("fx_busy",  32'(bus.busy), 32'h0);
      chk("fx_bcd",   32'(bus.entry_bcd), 32'h0);
      chk("fx_count", 32'(bus.entry_count), 32'h0);
      chk("fx_code",  32'(bus.code_out), 32'(DASHES));
      chk("fx_blink", 32'(bus.blink_out), 32'h0);

      // A digit during the pass hold and a digit in the exit cycle are both ignored.
      press(4'd1);
      bus.unlock_ok = 1'b1;
      tick();
      bus.unlock_ok = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (k > 0) tick();
         chk("pass_code",  32'(bus.code_out), 32'(codes(16, 16, 16, 16)));
         chk("pass_blink", 32'(bus.blink_out), 32'h0);
         chk("pass_busy",  32'(bus.busy), 32'h1);
         chk("pass_count", 32'(bus.entry_count), 32'h1);
         chk("pass_bcd",   32'(bus.entry_bcd), 32'h1000);
         bus.digit_valid = (k == 3) || (k == 9);
         bus.digit_in    = (k == 9) ? 4'd5 : 4'd9;
      end
      tick();
      bus.digit_valid = 1'b0;
      chk("px_busy",  32'(bus.busy), 32'h0);
      chk("px_count", 32'(bus.entry_count), 32'h0);
      chk("px_code",  32'(bus.code_out), 32'(DASHES));
      press(4'd5);
      chk("post_count", 32'(bus.entry_count), 32'h1);
      chk("post_code",  32'(bus.code_out), 32'(codes(5, 15, 15, 15)));
      pulse_clear();

      // Asynchronous reset mid-hold: no clock edge between assert and sample.
      press(4'd7);
      bus.unlock_ok = 1'b1;
      tick();
      bus.unlock_ok = 1'b0;
      repeat (5) tick();
      chk("pre_rst_busy", 32'(bus.busy), 32'h1);
      #2 rst = 1'b1;
      #1;
      chk("arst_code",  32'(bus.code_out), 32'(DASHES));
      chk("arst_blink", 32'(bus.blink_out), 32'h0);
      chk("arst_busy",  32'(bus.busy), 32'h0);
      chk("arst_count", 32'(bus.entry_count), 32'h0);
      chk("arst_bcd",   32'(bus.entry_bcd), 32'h0);
      chk("arst_full",  32'(bus.entry_full), 32'h0);
      rst = 1'b0;
      tick();
      chk("arst_idle_code", 32'(bus.code_out), 32'(DASHES));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
